fb_write_engine: RTL

- Command decoder between the UART receiver and the framebuffer write port.
- Consumes received bytes (valid strobe plus byte), parses a small big-endian command protocol, and issues single-cycle framebuffer writes.
- Covers single-pixel set, full-screen clear, and streamed pixel runs.
- The VGA scan-out path is untouched; this block only drives the framebuffer write side.

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/fb_byte_assembler.sv | 37 +++
 rtl/fb_write_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared opcode constants and command-decoder state encoding for the
// framebuffer write path.
package gpu_pkg;

  localparam logic [7:0] OP_SET_PIXEL = 8'h01;
  localparam logic [7:0] OP_CLEAR     = 8'h02;
  localparam logic [7:0] OP_STREAM    = 8'h03;

  localparam int FIELD_W = 24;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR0    = 4'd1,
    ST_ADDR1    = 4'd2,
    ST_ADDR2    = 4'd3,
    ST_CNT0     = 4'd4,
    ST_CNT1     = 4'd5,
    ST_CNT2     = 4'd6,
    ST_PIX_HI   = 4'd7,
    ST_PIX_LO   = 4'd8,
    ST_CLEARING = 4'd9
  } state_t;

endpackage

// File: rtl/fb_byte_assembler.sv
// Big-endian byte shifter: collects i_Num_Bytes bytes into a 24-bit field.
// o_Field/o_Done are valid combinationally on the strobe of the final byte.
module fb_byte_assembler
  import gpu_pkg::*;
(
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Restart,
  input  logic               i_Shift,
  input  logic [7:0]         i_Byte,
  input  logic [1:0]         i_Num_Bytes,
  output logic [FIELD_W-1:0] o_Field,
  output logic               o_Done
);

  // Only the two older bytes need storage; the newest byte comes straight
  // from the input so the full field is usable on the completing strobe.
  logic [FIELD_W-9:0] r_Field;
  logic [1:0]         r_Count;

  assign o_Field = {r_Field, i_Byte};
  assign o_Done  = i_Shift && (r_Count == i_Num_Bytes - 2'd1);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Field <= '0;
      r_Count <= '0;
    end else if (i_Restart) begin
      r_Field <= '0;
      r_Count <= '0;
    end else if (i_Shift) begin
      r_Field <= o_Field[FIELD_W-9:0];
      r_Count <= o_Done ? 2'd0 : r_Count + 2'd1;
    end
  end

endmodule

// File: rtl/fb_write_engine.sv
// UART command decoder driving the framebuffer write port (SET_PIXEL, CLEAR,
// STREAM). Define FB_WRITE_ENGINE_TIMEOUT_EN to abort stalled partial commands.
module fb_write_engine
  import gpu_pkg::*;
#(
  parameter int BITS_PER_PIXEL    = 12,
  parameter int FRAMEBUFFER_DEPTH = 307200,
  parameter int TIMEOUT_CYCLES    = 1_000_000
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  output logic                      o_Write_Enable,
  output logic [31:0]               o_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
  output logic                      o_Busy,
  output logic                      o_Cmd_Done,
  output logic                      o_Error
);

  localparam int CLR_W  = (FRAMEBUFFER_DEPTH > 1) ? $clog2(FRAMEBUFFER_DEPTH) : 1;
  // Wide enough for a 24-bit start address plus a 24-bit run without wrapping.
  localparam int ADDR_W = FIELD_W + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(FRAMEBUFFER_DEPTH);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(FRAMEBUFFER_DEPTH - 1);

  state_t              r_State;
  logic [7:0]          r_Cmd;
  logic [ADDR_W-1:0]   r_Addr;
  logic [FIELD_W-1:0]  r_Remain;
  logic [CLR_W-1:0]    r_Clr_Addr;

  logic [FIELD_W-1:0]  w_Addr_Field, w_Cnt_Field, w_Pix_Field;
  logic                w_Addr_Done, w_Cnt_Done, w_Pix_Done;
  logic                w_Restart, w_In_Collect, w_Timeout;
  logic [BITS_PER_PIXEL-1:0] w_Pix;
  logic                w_unused_pix;

  assign w_Restart    = (r_State == ST_IDLE);
  assign w_In_Collect = (r_State != ST_IDLE) && (r_State != ST_CLEARING);
  assign w_Pix        = w_Pix_Field[BITS_PER_PIXEL-1:0];
  assign w_unused_pix = ^w_Pix_Field[FIELD_W-1:BITS_PER_PIXEL];

  fb_byte_assembler u_addr (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Restart(w_Restart),
    .i_Shift(i_Rx_DV && (r_State inside {ST_ADDR0, ST_ADDR1, ST_ADDR2})),
    .i_Byte(i_Rx_Byte), .i_Num_Bytes(2'd3),
    .o_Field(w_Addr_Field), .o_Done(w_Addr_Done)
  );

  fb_byte_assembler u_cnt (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Restart(w_Restart),
    .i_Shift(i_Rx_DV && (r_State inside {ST_CNT0, ST_CNT1, ST_CNT2})),
    .i_Byte(i_Rx_Byte), .i_Num_Bytes(2'd3),
    .o_Field(w_Cnt_Field), .o_Done(w_Cnt_Done)
  );

  fb_byte_assembler u_pix (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Restart(w_Restart),
    .i_Shift(i_Rx_DV && (r_State inside {ST_PIX_HI, ST_PIX_LO})),
    .i_Byte(i_Rx_Byte), .i_Num_Bytes(2'd2),
    .o_Field(w_Pix_Field), .o_Done(w_Pix_Done)
  );

`ifdef FB_WRITE_ENGINE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_Timer;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)                        r_Timer <= '0;
    else if (i_Rx_DV || !w_In_Collect)  r_Timer <= '0;
    else                                r_Timer <= r_Timer + 1'b1;
  end

  assign w_Timeout = w_In_Collect && !i_Rx_DV && (r_Timer == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0) && w_In_Collect;
  assign w_Timeout        = 1'b0;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State        <= ST_IDLE;
      r_Cmd          <= '0;
      r_Addr         <= '0;
      r_Remain       <= '0;
      r_Clr_Addr     <= '0;
      o_Write_Enable <= 1'b0;
      o_Write_Addr   <= '0;
      o_Write_Data   <= '0;
      o_Busy         <= 1'b0;
      o_Cmd_Done     <= 1'b0;
      o_Error        <= 1'b0;
    end else begin
      o_Write_Enable <= 1'b0;
      o_Cmd_Done     <= 1'b0;
      o_Busy         <= 1'b0;
      if (w_Timeout) begin
        r_State <= ST_IDLE;
        o_Error <= 1'b1;
      end else begin
        case (r_State)
          ST_IDLE: if (i_Rx_DV) begin
            case (i_Rx_Byte)
              OP_SET_PIXEL, OP_STREAM: begin r_Cmd <= i_Rx_Byte; r_State <= ST_ADDR0;  end
              OP_CLEAR:                begin r_Cmd <= i_Rx_Byte; r_State <= ST_PIX_HI; end
              default:                 o_Error <= 1'b1;
            endcase
          end
          ST_ADDR0: if (i_Rx_DV) r_State <= ST_ADDR1;
          ST_ADDR1: if (i_Rx_DV) r_State <= ST_ADDR2;
          ST_ADDR2: if (w_Addr_Done) begin
            r_Addr  <= {1'b0, w_Addr_Field};
            r_State <= (r_Cmd == OP_STREAM) ? ST_CNT0 : ST_PIX_HI;
          end
          ST_CNT0: if (i_Rx_DV) r_State <= ST_CNT1;
          ST_CNT1: if (i_Rx_DV) r_State <= ST_CNT2;
          ST_CNT2: if (w_Cnt_Done) begin
            if (w_Cnt_Field == '0) begin
              o_Cmd_Done <= 1'b1;
              r_State    <= ST_IDLE;
            end else begin
              r_Remain <= w_Cnt_Field;
              r_State  <= ST_PIX_HI;
            end
          end
          ST_PIX_HI: if (i_Rx_DV) r_State <= ST_PIX_LO;
          ST_PIX_LO: if (w_Pix_Done) begin
            if (r_Cmd == OP_CLEAR) begin
              // First clear write issues here so Busy/WE start right after the pixel.
              o_Write_Enable <= 1'b1;
              o_Write_Addr   <= '0;
              o_Write_Data   <= w_Pix;
              o_Busy         <= 1'b1;
              r_Clr_Addr     <= CLR_W'(1);
              if (CLR_LAST == '0) begin
                o_Cmd_Done <= 1'b1;
                r_State    <= ST_IDLE;
              end else begin
                r_State <= ST_CLEARING;
              end
            end else begin
              if (r_Addr < DEPTH_A) begin
                o_Write_Enable <= 1'b1;
                o_Write_Addr   <= 32'(r_Addr);
                o_Write_Data   <= w_Pix;
              end else begin
                o_Error <= 1'b1;
              end
              if (r_Cmd == OP_STREAM && r_Remain != FIELD_W'(1)) begin
                r_Addr   <= r_Addr + 1'b1;
                r_Remain <= r_Remain - 1'b1;
                r_State  <= ST_PIX_HI;
              end else begin
                o_Cmd_Done <= 1'b1;
                r_State    <= ST_IDLE;
              end
            end
          end
          ST_CLEARING: begin
            o_Write_Enable <= 1'b1;
            o_Write_Addr   <= 32'(r_Clr_Addr);
            o_Busy         <= 1'b1;
            if (i_Rx_DV) o_Error <= 1'b1;
            if (r_Clr_Addr == CLR_LAST) begin
              o_Cmd_Done <= 1'b1;
              r_State    <= ST_IDLE;
            end else begin
              r_Clr_Addr <= r_Clr_Addr + 1'b1;
            end
          end
          default: r_State <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
